lif_layer: RTL and testbench
============================

LIF_LAYER -- requirements
Module: lif_layer

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, meaning the number of input spike lines.
REQ-002 The block SHALL have parameter N_OUT, default 2, meaning the number of LIF neurons.
REQ-003 The block SHALL have parameter N_CYCLES, default 10, meaning the timesteps per inference.
REQ-004 The block SHALL have parameter CNT_W, default 5, meaning the timestep and spike-count width.
REQ-005 The block SHALL have parameter W_W, default 4, meaning the signed weight width.
REQ-006 The block SHALL have parameter V_W, default 8, meaning the signed membrane-potential width.
REQ-007 The block SHALL have parameter LEAK_SHIFT, default 3, meaning the leak as an arithmetic right-shift amount.
REQ-008 The block SHALL have port clk, input, width 1: the single clock, rising edge.
REQ-009 The block SHALL have port rst_n, input, width 1: the reset, synchronous and active-low.
REQ-010 The block SHALL have port start, input, width 1: begins an inference when the block is idle or done.
REQ-011 The block SHALL have port thr, input, width V_W: the firing threshold, positive signed, captured at start.
REQ-012 The block SHALL have port w_flat, input, width N_OUT*N_IN*W_W: signed weights, where weight[o][i] occupies bits [(o*N_IN+i)*W_W +: W_W]; the port is held static during an inference.
REQ-013 The block SHALL have port sample, output, width 1: the request for the next input sample.
REQ-014 The block SHALL have port sample_ready, input, width 1: the source's acknowledge; in_spikes is valid when it is high.
REQ-015 The block SHALL have port in_spikes, input, width N_IN: the input spike vector.
REQ-016 The block SHALL have port out_spikes, output, width N_OUT: the per-timestep output spikes.
REQ-017 The block SHALL have port out_valid, output, width 1: a one-cycle pulse qualifying out_spikes.
REQ-018 The block SHALL have port spike_cnt, output, width N_OUT*CNT_W: the per-neuron spike totals.
REQ-019 The block SHALL have port ready, output, width 1: high when an inference is complete.
REQ-020 The block SHALL have port busy, output, width 1: high while an inference is in progress.

Function
REQ-021 The FSM SHALL have states IDLE, REQ, UPDATE and DONE.
REQ-022 In IDLE or DONE, start=1 SHALL clear every membrane to 0, every spike_cnt field to 0 and the step counter to 0, capture thr, clear ready and go to REQ.
REQ-023 In REQ, sample SHALL be 1; a transfer occurs on the rising edge where sample and sample_ready are both 1, capturing in_spikes and moving to UPDATE.
REQ-024 While sample_ready is 0 in REQ, the block SHALL stay in REQ indefinitely with no state change.
REQ-025 In UPDATE, each neuron o SHALL compute v_next = v - (v >>> LEAK_SHIFT) + sum over i with spike[i]=1 of weight[o][i], using a full-width intermediate saturated to the signed V_W range with no wrap-around.
REQ-026 If v_next >= thr (signed compare), the neuron SHALL fire: out_spikes[o]=1, v=0 and spike_cnt[o] incremented, saturating at 2^CNT_W-1; otherwise v=v_next and out_spikes[o]=0.
REQ-027 out_spikes and out_valid SHALL be registered in UPDATE, so out_valid=1 exactly one cycle after each UPDATE and 0 otherwise.
REQ-028 From UPDATE, when step = N_CYCLES-1 the block SHALL go to DONE; otherwise it SHALL increment step and go to REQ, giving a minimum of 2 cycles per timestep.
REQ-029 In DONE, ready SHALL be 1 and spike_cnt SHALL hold until the next start.
REQ-030 busy SHALL be 1 in REQ and UPDATE, and 0 in IDLE and DONE.
REQ-031 start while busy=1 SHALL be ignored.
REQ-032 sample_ready outside REQ SHALL be ignored.

Reset
REQ-033 rst_n=0 at a rising edge SHALL, including mid-inference, force IDLE, all membranes to 0, spike_cnt to 0, step to 0, and sample, ready, busy, out_valid and out_spikes to 0.
REQ-034 Reset SHALL take priority over start and sample_ready in the same cycle.

Structure
REQ-035 Package snn_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-036 Each neuron SHALL be a lif_neuron sub-module (membrane register, leak, weighted sum, saturation, compare, counter), instantiated N_OUT times by generate; lif_layer holds the FSM and step counter.

Verification (N_IN=4, N_OUT=2, N_CYCLES=10, V_W=8, LEAK_SHIFT=3)
REQ-037 Reset then idle: all outputs SHALL be 0 and sample SHALL stay 0 without start.
REQ-038 Stimulus: w0 all +4, w1 all 0, thr=8, in_spikes=4'hF, sample_ready=1. Required: out_spikes=2'b01 on every one of the 10 out_valid pulses, spike_cnt0=10, spike_cnt1=0, then ready=1.
REQ-039 Stimulus: w0[0]=+3, other weights 0, in_spikes=4'b0001, thr=8. Required: neuron0 fires on timesteps 3, 6 and 9 (v = 3, 6, fire), and final spike_cnt0=3.
REQ-040 Stimulus: all weights -8, in_spikes=4'hF, thr=8. Required: v saturates at -128 and never wraps, no spikes occur, and spike_cnt=0.
REQ-041 Stimulus: hold sample_ready=0 for 5 cycles at timestep 4, and pulse start at the same time. Required: sample stays 1, no out_valid pulses occur, start is ignored, and final counts match the unstalled run.
REQ-042 Stimulus: assert rst_n=0 during timestep 6, then start. Required: all outputs are 0 after reset, and the next run produces full results identical to a fresh run.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and default sizing for the spiking-neural-network layer.
// The FSM state enum lives here so the bench and any future layers agree on it.
package snn_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      UPDATE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int DEF_N_IN       = 4;
   localparam int DEF_N_OUT      = 2;
   localparam int DEF_N_CYCLES   = 10;
   localparam int DEF_CNT_W      = 5;
   localparam int DEF_W_W        = 4;
   localparam int DEF_V_W        = 8;
   localparam int DEF_LEAK_SHIFT = 3;

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: membrane register, shift leak, weighted
// spike sum, saturation to the membrane range, threshold compare and spike counter.
module lif_neuron
   import snn_pkg::*;
#(
   parameter int N_IN       = DEF_N_IN,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int W_W        = DEF_W_W,
   parameter int V_W        = DEF_V_W,
   parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 en,
   input  logic [V_W-1:0]       thr,
   input  logic [N_IN*W_W-1:0]  w,
   input  logic [N_IN-1:0]      spikes,
   output logic                 fire,
   output logic [CNT_W-1:0]     cnt
);

   // Wide enough that v - leak + N_IN max-magnitude weights can never wrap.
   localparam int S_W = V_W + W_W + $clog2(N_IN + 1) + 2;
   localparam logic signed [S_W-1:0] V_MAX = S_W'((2 ** (V_W - 1)) - 1);
   localparam logic signed [S_W-1:0] V_MIN = ~V_MAX;

   logic [V_W-1:0]          v;
   logic [V_W-1:0]          v_next;
   logic signed [S_W-1:0]   v_ext;
   logic signed [S_W-1:0]   acc;
   logic signed [S_W-1:0]   w_ext;
   logic                    fire_c;

   always_comb begin
      v_ext = {{(S_W - V_W){v[V_W-1]}}, v};
      acc   = v_ext - (v_ext >>> LEAK_SHIFT);
      w_ext = '0;
      for (int i = 0; i < N_IN; i++) begin
         w_ext = {{(S_W - W_W){w[i*W_W + W_W - 1]}}, w[i*W_W +: W_W]};
         if (spikes[i]) acc = acc + w_ext;
      end
      if (acc > V_MAX)      v_next = V_MAX[V_W-1:0];
      else if (acc < V_MIN) v_next = V_MIN[V_W-1:0];
      else                  v_next = acc[V_W-1:0];
      fire_c = $signed(v_next) >= $signed(thr);
   end

   // fire is a one-cycle strobe: only the cycle after an update may carry a spike.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v    <= '0;
         cnt  <= '0;
         fire <= 1'b0;
      end else begin
         fire <= 1'b0;
         if (clr) begin
            v   <= '0;
            cnt <= '0;
         end else if (en) begin
            if (fire_c) begin
               v    <= '0;
               fire <= 1'b1;
               if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
            end else begin
               v <= v_next;
            end
         end
      end
   end

endmodule

// File: rtl/lif_layer.sv
// Layer of N_OUT LIF neurons sharing one handshake-driven timestep sequencer.
// Each timestep requests an input sample, then updates every neuron in parallel.
module lif_layer
   import snn_pkg::*;
#(
   parameter int N_IN       = DEF_N_IN,
   parameter int N_OUT      = DEF_N_OUT,
   parameter int N_CYCLES   = DEF_N_CYCLES,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int W_W        = DEF_W_W,
   parameter int V_W        = DEF_V_W,
   parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [V_W-1:0]             thr,
   input  logic [N_OUT*N_IN*W_W-1:0]  w_flat,
   output logic                       sample,
   input  logic                       sample_ready,
   input  logic [N_IN-1:0]            in_spikes,
   output logic [N_OUT-1:0]           out_spikes,
   output logic                       out_valid,
   output logic [N_OUT*CNT_W-1:0]     spike_cnt,
   output logic                       ready,
   output logic                       busy
);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  step;
   logic [V_W-1:0]    thr_q;
   logic [N_IN-1:0]   spk_q;
   logic              clr;
   logic              upd;
   logic              last_step;
   logic              xfer;

   assign last_step = (step == CNT_W'(N_CYCLES - 1));
   assign xfer      = (state == REQ) && sample_ready;
   assign clr       = start && ((state == IDLE) || (state == DONE));
   assign upd       = (state == UPDATE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      sample   = 1'b0;
      busy     = 1'b0;
      ready    = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = REQ;
         end
         REQ: begin
            sample = 1'b1;
            busy   = 1'b1;
            if (sample_ready) state_nx = UPDATE;
         end
         UPDATE: begin
            busy     = 1'b1;
            state_nx = last_step ? DONE : REQ;
         end
         DONE: begin
            ready = 1'b1;
            if (start) state_nx = REQ;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         step      <= '0;
         thr_q     <= '0;
         spk_q     <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= upd;
         if (clr) begin
            step  <= '0;
            thr_q <= thr;
         end
         if (xfer) spk_q <= in_spikes;
         if (upd && !last_step) step <= step + 1'b1;
      end
   end

   for (genvar o = 0; o < N_OUT; o++) begin : g_neuron
      lif_neuron #(
         .N_IN       (N_IN),
         .CNT_W      (CNT_W),
         .W_W        (W_W),
         .V_W        (V_W),
         .LEAK_SHIFT (LEAK_SHIFT)
      ) u_neuron (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr    (clr),
         .en     (upd),
         .thr    (thr_q),
         .w      (w_flat[o*N_IN*W_W +: N_IN*W_W]),
         .spikes (spk_q),
         .fire   (out_spikes[o]),
         .cnt    (spike_cnt[o*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_lif_layer.sv
// Directed bench for lif_layer: saturating drive, sparse drive, negative saturation,
// sample stall with ignored start, and mid-inference reset followed by a clean rerun.
module tb_lif_layer;
   import snn_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  thr;
   logic [31:0] w_flat;
   logic        sample;
   logic        sample_ready;
   logic [3:0]  in_spikes;
   logic [1:0]  out_spikes;
   logic        out_valid;
   logic [9:0]  spike_cnt;
   logic        ready;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;

   lif_layer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .thr          (thr),
      .w_flat       (w_flat),
      .sample       (sample),
      .sample_ready (sample_ready),
      .in_spikes    (in_spikes),
      .out_spikes   (out_spikes),
      .out_valid    (out_valid),
      .spike_cnt    (spike_cnt),
      .ready        (ready),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_sample"},  {31'b0, sample},     32'h0);
      chk({tag, "_busy"},    {31'b0, busy},       32'h0);
      chk({tag, "_ready"},   {31'b0, ready},      32'h0);
      chk({tag, "_ovalid"},  {31'b0, out_valid},  32'h0);
      chk({tag, "_ospikes"}, {30'b0, out_spikes}, 32'h0);
      chk({tag, "_cnt"},     {22'b0, spike_cnt},  32'h0);
   endtask

   // One inference. stall_at/abort_at >= 0 inject a stall or reset after that many pulses.
   task automatic run(input string tag, input logic [31:0] w, input logic [3:0] spk,
                      input logic [9:0] exp0, input logic [9:0] exp1,
                      input int c0, input int c1, input int stall_at, input int abort_at);
      int  pulses  = 0;
      bit  fin     = 0;
      bit  stalled = 0;
      bit  aborted = 0;
      w_flat = w; thr = 8'd8; in_spikes = spk; sample_ready = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy0"},  {31'b0, busy},      32'h1);
      chk({tag, "_ready0"}, {31'b0, ready},     32'h0);
      chk({tag, "_cnt0"},   {22'b0, spike_cnt}, 32'h0);
      for (int cyc = 0; cyc < 300 && !fin && !aborted; cyc++) begin
         if (out_valid) begin
            if (pulses < 10)
               chk($sformatf("%s_spk%0d", tag, pulses), {30'b0, out_spikes},
                   {30'b0, exp1[pulses], exp0[pulses]});
            else
               chk({tag, "_extra_pulse"}, pulses, 32'd9);
            pulses++;
         end
         if (abort_at >= 0 && pulses == abort_at) begin
            rst_n = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk_quiet({tag, "_rst"});
            rst_n = 1'b1;
            @(negedge clk);
            chk_quiet({tag, "_postrst"});
            aborted = 1;
         end else if (stall_at >= 0 && !stalled && sample && pulses == stall_at) begin
            stalled = 1;
            sample_ready = 1'b0;
            start = 1'b1;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               start = 1'b0;
               chk($sformatf("%s_stl_sample%0d", tag, k), {31'b0, sample},    32'h1);
               chk($sformatf("%s_stl_ovalid%0d", tag, k), {31'b0, out_valid}, 32'h0);
               chk($sformatf("%s_stl_busy%0d", tag, k),   {31'b0, busy},      32'h1);
            end
            sample_ready = 1'b1;
            @(negedge clk);
         end else if (ready) begin
            fin = 1;
         end else begin
            @(negedge clk);
         end
      end
      if (!aborted) begin
         chk({tag, "_finished"}, {31'b0, fin}, 32'h1);
         chk({tag, "_npulses"},  pulses, 32'd10);
         chk({tag, "_cnt"},      {22'b0, spike_cnt}, {22'b0, c1[4:0], c0[4:0]});
         in_spikes = ~spk; sample_ready = 1'b0;
         repeat (3) @(negedge clk);
         chk({tag, "_hold_ready"}, {31'b0, ready},     32'h1);
         chk({tag, "_hold_busy"},  {31'b0, busy},      32'h0);
         chk({tag, "_hold_samp"},  {31'b0, sample},    32'h0);
         chk({tag, "_hold_cnt"},   {22'b0, spike_cnt}, {22'b0, c1[4:0], c0[4:0]});
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; thr = 8'd8; w_flat = '0;
      sample_ready = 1'b1; in_spikes = 4'h0;
      repeat (2) @(negedge clk);
      chk_quiet("reset");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk_quiet("idle");

      // w0 = +4 everywhere: v jumps to 16 every step, always fires.
      run("all4", 32'h0000_4444, 4'hF, 10'h3FF, 10'h000, 10, 0, -1, -1);
      // single +3 weight: v = 3, 6, fire -> fires on steps 3, 6, 9.
      run("sparse", 32'h0000_0003, 4'h1, 10'h124, 10'h000, 3, 0, -1, -1);
      // all -8: membrane walks down and pins at -128 by step 6.
      run("neg", 32'h8888_8888, 4'hF, 10'h000, 10'h000, 0, 0, -1, -1);
      chk("neg_v0", {24'b0, dut.g_neuron[0].u_neuron.v}, 32'h80);
      chk("neg_v1", {24'b0, dut.g_neuron[1].u_neuron.v}, 32'h80);
      // stall before the fifth sample; results identical to the unstalled run.
      run("stall", 32'h0000_0003, 4'h1, 10'h124, 10'h000, 3, 0, 4, -1);
      // reset during step 6, then a fresh full run.
      run("abort", 32'h0000_0003, 4'h1, 10'h124, 10'h000, 3, 0, -1, 5);
      run("rerun", 32'h0000_0003, 4'h1, 10'h124, 10'h000, 3, 0, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
